// File: rtl/edm_pkg.sv
// Shared types and constants for the edge-detector memory controller.
package edm_pkg;

    localparam int unsigned ADDR_W = 24;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_FILL  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_RDONE,
        ST_WR,
        ST_WDONE
    } edm_state_e;

endpackage

// File: rtl/edm_addr_gen.sv
// Combinational byte-address generation for window-row reads and result writes.
module edm_addr_gen
    import edm_pkg::*;
(
    input  logic [1:0]        row_i,
    input  logic [ADDR_W-1:0] rd_base_i,
    input  logic [ADDR_W-1:0] wr_base_i,
    input  logic [19:0]       rpixnum_i,
    input  logic [19:0]       wpixnum_i,
    input  logic [11:0]       width_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o
);

    logic [ADDR_W-1:0] row_off;

    // Sums wrap naturally at 2^24; operands are zero-extended.
    always_comb begin
        row_off = '0;
        case (row_i)
            2'd1:    row_off = {12'b0, width_i};
            2'd2:    row_off = {11'b0, width_i, 1'b0};
            default: row_off = '0;
        endcase
        rd_addr_o = rd_base_i + {4'b0, rpixnum_i} + row_off;
        wr_addr_o = wr_base_i + {4'b0, wpixnum_i};
    end

endmodule

// File: rtl/edm_mem_ctrl.sv
// Memory controller: fetches a 3x4 pixel window row by row and writes two result pixels.
module edm_mem_ctrl
    import edm_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                fill_buff,
    input  logic [1:0]          ED_mode,
    input  logic [19:0]         ED_rpixnum,
    input  logic [19:0]         ED_wpixnum,
    input  logic [15:0]         ED_wdata,
    input  logic [11:0]         image_width,
    input  logic [ADDR_W-1:0]   rd_base,
    input  logic [ADDR_W-1:0]   wr_base,
    output logic [95:0]         ED_rdata,
    output logic                buff_filled,
    output logic                ED_dfb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [15:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_ready
);

    edm_state_e        state_q;
    logic [95:0]       rdata_q;
    logic              buff_filled_q;
    logic              dfb_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ren_q;
    logic              wen_q;
    logic [15:0]       wdata_q;

    logic [1:0]        row_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_d;

    // Outputs are registered, so the generator is fed the row about to be entered.
    always_comb begin
        row_d = 2'd0;
        case (state_q)
            ST_RD0:  row_d = 2'd1;
            ST_RD1:  row_d = 2'd2;
            default: row_d = 2'd0;
        endcase
    end

    edm_addr_gen u_addr_gen (
        .row_i     (row_d),
        .rd_base_i (rd_base),
        .wr_base_i (wr_base),
        .rpixnum_i (ED_rpixnum),
        .wpixnum_i (ED_wpixnum),
        .width_i   (image_width),
        .rd_addr_o (rd_addr_d),
        .wr_addr_o (wr_addr_d)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            rdata_q       <= '0;
            buff_filled_q <= 1'b0;
            dfb_q         <= 1'b0;
            addr_q        <= '0;
            ren_q         <= 1'b0;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
        end else begin
            buff_filled_q <= 1'b0;
            dfb_q         <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fill_buff) begin
                        state_q <= ST_RD0;
                        ren_q   <= 1'b1;
                        addr_q  <= rd_addr_d;
                    end else if (ED_mode == MODE_WRITE) begin
                        state_q <= ST_WR;
                        wen_q   <= 1'b1;
                        addr_q  <= wr_addr_d;
                        wdata_q <= ED_wdata;
                    end
                end
                ST_RD0: begin
                    if (mem_ready) begin
                        rdata_q[31:0] <= mem_rdata;
                        state_q       <= ST_RD1;
                        addr_q        <= rd_addr_d;
                    end
                end
                ST_RD1: begin
                    if (mem_ready) begin
                        rdata_q[63:32] <= mem_rdata;
                        state_q        <= ST_RD2;
                        addr_q         <= rd_addr_d;
                    end
                end
                ST_RD2: begin
                    if (mem_ready) begin
                        rdata_q[95:64] <= mem_rdata;
                        state_q        <= ST_RDONE;
                        ren_q          <= 1'b0;
                        addr_q         <= '0;
                        buff_filled_q  <= 1'b1;
                    end
                end
                ST_RDONE: state_q <= ST_IDLE;
                ST_WR: begin
                    if (mem_ready) begin
                        state_q <= ST_WDONE;
                        wen_q   <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        dfb_q   <= 1'b1;
                    end
                end
                ST_WDONE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign ED_rdata    = rdata_q;
    assign buff_filled = buff_filled_q;
    assign ED_dfb      = dfb_q;
    assign mem_addr    = addr_q;
    assign mem_ren     = ren_q;
    assign mem_wen     = wen_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_edm_mem_ctrl.sv
// Self-checking bench for edm_mem_ctrl: directed cases plus randomized transactions against a reference model.
module tb_edm_mem_ctrl;
    import edm_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        fill_buff = 1'b0;
    logic [1:0]  ED_mode = 2'b00;
    logic [19:0] ED_rpixnum = '0;
    logic [19:0] ED_wpixnum = '0;
    logic [15:0] ED_wdata = '0;
    logic [11:0] image_width = '0;
    logic [23:0] rd_base = '0;
    logic [23:0] wr_base = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [95:0] ED_rdata;
    logic        buff_filled;
    logic        ED_dfb;
    logic [23:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] mem_wdata;

    edm_mem_ctrl dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .fill_buff   (fill_buff),
        .ED_mode     (ED_mode),
        .ED_rpixnum  (ED_rpixnum),
        .ED_wpixnum  (ED_wpixnum),
        .ED_wdata    (ED_wdata),
        .image_width (image_width),
        .rd_base     (rd_base),
        .wr_base     (wr_base),
        .ED_rdata    (ED_rdata),
        .buff_filled (buff_filled),
        .ED_dfb      (ED_dfb),
        .mem_addr    (mem_addr),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [95:0] model_rdata = '0;
    logic [23:0] obs_addr [3];
    int          last_lat = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rd_addr_model(input logic [23:0] base, input logic [19:0] pix,
                                                  input logic [11:0] w, input int n);
        longint unsigned a;
        a = longint'(base) + longint'(pix) + longint'(n) * longint'(w);
        return a[23:0];
    endfunction

    function automatic logic [23:0] wr_addr_model(input logic [23:0] base, input logic [19:0] pix);
        longint unsigned a;
        a = longint'(base) + longint'(pix);
        return a[23:0];
    endfunction

    // Strobe exclusivity and idle-bus zeroing hold every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("strobe_excl", 96'(mem_ren & mem_wen), '0);
            if (!mem_wen) check_eq("wdata_zero", 96'(mem_wdata), '0);
            if (!mem_ren && !mem_wen) check_eq("addr_zero", 96'(mem_addr), '0);
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic fill_txn(input logic [23:0] base, input logic [19:0] pix, input logic [11:0] w,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input int wt0, input int wt1, input int wt2, input bit collide);
        int          waits [3];
        logic [31:0] words [3];
        int          cyc;
        logic [23:0] ea;
        waits = '{wt0, wt1, wt2};
        words = '{w0, w1, w2};
        rd_base     = base;
        ED_rpixnum  = pix;
        image_width = w;
        fill_buff   = 1'b1;
        ED_mode     = collide ? MODE_WRITE : MODE_IDLE;
        mem_ready   = 1'b0;
        cyc = 0;
        for (int n = 0; n < 3; n++) begin
            ea = rd_addr_model(base, pix, w, n);
            for (int k = 0; k <= waits[n]; k++) begin
                @(negedge clk);
                cyc++;
                if (k == 0) obs_addr[n] = mem_addr;
                check_eq("rd_ren", 96'(mem_ren), 96'(1));
                check_eq("rd_addr", 96'(mem_addr), 96'(ea));
                check_eq("rd_no_bf", 96'(buff_filled), '0);
                check_eq("rd_no_dfb", 96'(ED_dfb), '0);
                mem_ready = (k == waits[n]);
                mem_rdata = mem_ready ? words[n] : $urandom;
                if (!collide) begin
                    fill_buff = 1'($urandom_range(0, 1));
                    ED_mode   = 2'($urandom_range(0, 3));
                end
            end
        end
        @(negedge clk);
        cyc++;
        last_lat    = cyc;
        model_rdata = {words[2], words[1], words[0]};
        check_eq("bf_pulse", 96'(buff_filled), 96'(1));
        check_eq("rdata", ED_rdata, model_rdata);
        check_eq("bf_ren_low", 96'(mem_ren), '0);
        fill_buff = 1'b0;
        mem_ready = 1'b0;
        if (!collide) ED_mode = MODE_IDLE;
        @(negedge clk);
        check_eq("bf_once", 96'(buff_filled), '0);
        check_eq("idle_ren", 96'(mem_ren), '0);
        check_eq("rdata_hold", ED_rdata, model_rdata);
    endtask

    task automatic wr_txn(input logic [23:0] base, input logic [19:0] pix, input logic [15:0] data, input int wt);
        int          cyc;
        logic [23:0] ea;
        wr_base    = base;
        ED_wpixnum = pix;
        ED_wdata   = data;
        ED_mode    = MODE_WRITE;
        fill_buff  = 1'b0;
        mem_ready  = 1'b0;
        ea  = wr_addr_model(base, pix);
        cyc = 0;
        for (int k = 0; k <= wt; k++) begin
            @(negedge clk);
            cyc++;
            if (k == 0) obs_addr[0] = mem_addr;
            check_eq("wr_wen", 96'(mem_wen), 96'(1));
            check_eq("wr_ren", 96'(mem_ren), '0);
            check_eq("wr_addr", 96'(mem_addr), 96'(ea));
            check_eq("wr_data", 96'(mem_wdata), 96'(data));
            check_eq("wr_no_dfb", 96'(ED_dfb), '0);
            mem_ready = (k == wt);
            mem_rdata = $urandom;
            ED_mode   = 2'($urandom_range(0, 3));
            fill_buff = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cyc++;
        last_lat = cyc;
        check_eq("dfb_pulse", 96'(ED_dfb), 96'(1));
        check_eq("dfb_wen_low", 96'(mem_wen), '0);
        ED_mode   = MODE_IDLE;
        fill_buff = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("dfb_once", 96'(ED_dfb), '0);
        check_eq("wr_idle_wen", 96'(mem_wen), '0);
        check_eq("wr_rdata_hold", ED_rdata, model_rdata);
    endtask

    task automatic reset_in_rd2();
        rd_base     = 24'($urandom);
        ED_rpixnum  = 20'($urandom);
        image_width = 12'($urandom);
        fill_buff   = 1'b1;
        ED_mode     = MODE_IDLE;
        mem_ready   = 1'b1;
        mem_rdata   = $urandom;
        repeat (3) @(negedge clk);
        check_eq("rst_pre_ren", 96'(mem_ren), 96'(1));
        n_rst = 1'b0;
        #1;
        model_rdata = '0;
        check_eq("rst_ren", 96'(mem_ren), '0);
        check_eq("rst_wen", 96'(mem_wen), '0);
        check_eq("rst_addr", 96'(mem_addr), '0);
        check_eq("rst_wdata", 96'(mem_wdata), '0);
        check_eq("rst_bf", 96'(buff_filled), '0);
        check_eq("rst_dfb", 96'(ED_dfb), '0);
        check_eq("rst_rdata", ED_rdata, model_rdata);
        fill_buff = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        #2;
        check_eq("init_rdata", ED_rdata, '0);
        check_eq("init_ren", 96'(mem_ren), '0);
        check_eq("init_wen", 96'(mem_wen), '0);
        check_eq("init_addr", 96'(mem_addr), '0);
        check_eq("init_bf", 96'(buff_filled), '0);
        check_eq("init_dfb", 96'(ED_dfb), '0);
        repeat (2) @(negedge clk);
        n_rst  = 1'b1;
        mon_en = 1'b1;

        fill_txn(24'h001000, 20'd0, 12'd8, 32'h04030201, 32'h08070605, 32'h0C0B0A09, 0, 0, 0, 1'b0);
        check_eq("basic_a0", 96'(obs_addr[0]), 96'(24'h001000));
        check_eq("basic_a1", 96'(obs_addr[1]), 96'(24'h001008));
        check_eq("basic_a2", 96'(obs_addr[2]), 96'(24'h001010));
        check_eq("basic_rdata", ED_rdata, 96'h0C0B0A09_08070605_04030201);
        check_eq("basic_lat", 96'(last_lat), 96'(4));

        wr_txn(24'h002000, 20'd6, 16'h3264, 0);
        check_eq("wr_basic_addr", 96'(obs_addr[0]), 96'(24'h002006));
        check_eq("wr_basic_lat", 96'(last_lat), 96'(2));

        fill_txn(24'h001000, 20'd0, 12'd8, $urandom, $urandom, $urandom, 0, 3, 0, 1'b0);
        check_eq("ws_a1", 96'(obs_addr[1]), 96'(24'h001008));
        check_eq("ws_lat", 96'(last_lat), 96'(7));

        fill_txn(24'hFFFFFC, 20'd2, 12'd8, $urandom, $urandom, $urandom, 0, 0, 0, 1'b0);
        check_eq("wrap_a0", 96'(obs_addr[0]), 96'(24'hFFFFFE));
        check_eq("wrap_a1", 96'(obs_addr[1]), 96'(24'h000006));
        check_eq("wrap_a2", 96'(obs_addr[2]), 96'(24'h00000E));

        wr_base    = 24'h00A000;
        ED_wpixnum = 20'd3;
        ED_wdata   = 16'hBEEF;
        fill_txn(24'h003000, 20'd5, 12'd16, $urandom, $urandom, $urandom, 1, 0, 2, 1'b1);
        wr_txn(24'h00A000, 20'd3, 16'hBEEF, 1);
        check_eq("coll_wr_addr", 96'(obs_addr[0]), 96'(24'h00A003));

        reset_in_rd2();
        fill_txn(24'h004000, 20'd1, 12'd4, $urandom, $urandom, $urandom, 0, 0, 0, 1'b0);
        check_eq("post_rst_lat", 96'(last_lat), 96'(4));

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                fill_txn(24'($urandom), 20'($urandom), 12'($urandom), $urandom, $urandom, $urandom,
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            end else if (sel == 1) begin
                wr_txn(24'($urandom), 20'($urandom), 16'($urandom), $urandom_range(0, 3));
            end else begin
                wr_base    = 24'($urandom);
                ED_wpixnum = 20'($urandom);
                ED_wdata   = 16'($urandom);
                fill_txn(24'($urandom), 20'($urandom), 12'($urandom), $urandom, $urandom, $urandom,
                         $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
                wr_txn(wr_base, ED_wpixnum, ED_wdata, $urandom_range(0, 2));
            end
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
